lc3_control: RTL and testbench

LC3_CONTROL -- requirements
Module: lc3_control

---
 rtl/lc3_control_if.sv | 31 +++
 rtl/lc3_control.sv | 244 ++++++++++++++++++++++++
 tb/tb_lc3_control.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lc3_control_if.sv
// Control bundle between the LC-3 sequencer and its datapath/memory.
// The master modport is the controller; the slave modport is the datapath side.
interface lc3_control_if;
  logic [15:0] IR;
  logic        N, Z, P;
  logic        mem_ready;

  logic [1:0]  aluControl;
  logic [2:0]  SR1, SR2, DR;
  logic [1:0]  selPC;
  logic        selEAB1;
  logic [1:0]  selEAB2;
  logic        selMAR, selMDR;
  logic        enaALU, enaPC, enaMARM, enaMDR;
  logic        ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE;
  logic        memEN, memWE, halted, retire;

  modport master (
    input  IR, N, Z, P, mem_ready,
    output aluControl, SR1, SR2, DR, selPC, selEAB1, selEAB2, selMAR, selMDR,
           enaALU, enaPC, enaMARM, enaMDR, ldPC, ldIR, ldMAR, ldMDR, regWE,
           flagWE, memEN, memWE, halted, retire
  );

  modport slave (
    output IR, N, Z, P, mem_ready,
    input  aluControl, SR1, SR2, DR, selPC, selEAB1, selEAB2, selMAR, selMDR,
           enaALU, enaPC, enaMARM, enaMDR, ldPC, ldIR, ldMAR, ldMDR, regWE,
           flagWE, memEN, memWE, halted, retire
  );
endinterface

// File: rtl/lc3_control.sv
// Multi-cycle LC-3 control sequencer; outputs are decoded from the state register and IR.
// Define LC3_INDIRECT_EN to enable LDI/STI (IND state + indirect flag); otherwise they halt.
module lc3_control (
  input  logic          clk,
  input  logic          rst,
  lc3_control_if.master bus
);

  typedef enum logic [4:0] {
    S_RST, S_F0, S_F1, S_F2, S_DEC, S_EXE, S_BR, S_JMP, S_JSR, S_LEA,
    S_AD, S_RD, S_LDW, S_STD, S_WR, S_TR0, S_TR1, S_TR2, S_TR3, S_HALT
`ifdef LC3_INDIRECT_EN
    , S_IND
`endif
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD   = 4'b0010,
                         OP_ST  = 4'b0011, OP_JSR = 4'b0100, OP_AND  = 4'b0101,
                         OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT  = 4'b1001,
                         OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP  = 4'b1100,
                         OP_LEA = 4'b1110, OP_TRAP = 4'b1111;

  state_e     state_q;
  logic [3:0] opcode;
  logic       br_taken;

  assign opcode   = bus.IR[15:12];
  assign br_taken = (bus.IR[11] & bus.N) | (bus.IR[10] & bus.Z) | (bus.IR[9] & bus.P);

  function automatic state_e dec_state(input logic [3:0] op);
    case (op)
      OP_ADD, OP_AND, OP_NOT:        dec_state = S_EXE;
      OP_BR:                         dec_state = S_BR;
      OP_JMP:                        dec_state = S_JMP;
      OP_JSR:                        dec_state = S_JSR;
      OP_LEA:                        dec_state = S_LEA;
      OP_LD, OP_ST, OP_LDR, OP_STR:  dec_state = S_AD;
`ifdef LC3_INDIRECT_EN
      OP_LDI, OP_STI:                dec_state = S_AD;
`endif
      OP_TRAP:                       dec_state = S_TR0;
      default:                       dec_state = S_HALT;
    endcase
  endfunction

`ifdef LC3_INDIRECT_EN
  // Set once the pointer fetch of LDI/STI has been done, so the second RD goes on to LDW.
  logic ind_used_q;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RST;
`ifdef LC3_INDIRECT_EN
      ind_used_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_RST: state_q <= S_F0;
        S_F0: begin
          state_q <= S_F1;
`ifdef LC3_INDIRECT_EN
          ind_used_q <= 1'b0;
`endif
        end
        S_F1:  if (bus.mem_ready) state_q <= S_F2;
        S_F2:  state_q <= S_DEC;
        S_DEC: state_q <= dec_state(opcode);
        S_AD:  state_q <= (opcode == OP_ST || opcode == OP_STR) ? S_STD : S_RD;
        S_RD: begin
          if (bus.mem_ready) begin
`ifdef LC3_INDIRECT_EN
            if ((opcode == OP_LDI || opcode == OP_STI) && !ind_used_q) state_q <= S_IND;
            else state_q <= S_LDW;
`else
            state_q <= S_LDW;
`endif
          end
        end
`ifdef LC3_INDIRECT_EN
        S_IND: begin
          ind_used_q <= 1'b1;
          state_q    <= (opcode == OP_LDI) ? S_RD : S_STD;
        end
`endif
        S_STD: state_q <= S_WR;
        S_WR:  if (bus.mem_ready) state_q <= S_F0;
        S_TR0: state_q <= S_TR1;
        S_TR1: state_q <= S_TR2;
        S_TR2: if (bus.mem_ready) state_q <= S_TR3;
        S_EXE, S_BR, S_JMP, S_JSR, S_LEA, S_LDW, S_TR3: state_q <= S_F0;
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_RST;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    bus.aluControl = 2'b00;
    bus.SR1        = 3'd0;
    bus.SR2        = 3'd0;
    bus.DR         = 3'd0;
    bus.selPC      = 2'b00;
    bus.selEAB1    = 1'b0;
    bus.selEAB2    = 2'b00;
    bus.selMAR     = 1'b0;
    bus.selMDR     = 1'b0;
    bus.enaALU     = 1'b0;
    bus.enaPC      = 1'b0;
    bus.enaMARM    = 1'b0;
    bus.enaMDR     = 1'b0;
    bus.ldPC       = 1'b0;
    bus.ldIR       = 1'b0;
    bus.ldMAR      = 1'b0;
    bus.ldMDR      = 1'b0;
    bus.regWE      = 1'b0;
    bus.flagWE     = 1'b0;
    bus.memEN      = 1'b0;
    bus.memWE      = 1'b0;
    bus.halted     = 1'b0;
    bus.retire     = 1'b0;
    case (state_q)
      S_F0: begin
        bus.enaPC = 1'b1;
        bus.ldMAR = 1'b1;
        bus.ldPC  = 1'b1;
      end
      S_F1, S_RD, S_TR2: begin
        bus.memEN  = 1'b1;
        bus.selMDR = 1'b1;
        bus.ldMDR  = bus.mem_ready;
      end
      S_F2: begin
        bus.enaMDR = 1'b1;
        bus.ldIR   = 1'b1;
      end
      S_EXE: begin
        bus.SR1    = bus.IR[8:6];
        bus.SR2    = bus.IR[2:0];
        bus.DR     = bus.IR[11:9];
        bus.enaALU = 1'b1;
        bus.regWE  = 1'b1;
        bus.flagWE = 1'b1;
        bus.retire = 1'b1;
        case (opcode)
          OP_ADD:  bus.aluControl = 2'b01;
          OP_AND:  bus.aluControl = 2'b10;
          default: bus.aluControl = 2'b11;
        endcase
      end
      S_BR: begin
        bus.retire = 1'b1;
        if (br_taken) begin
          bus.ldPC    = 1'b1;
          bus.selPC   = 2'b01;
          bus.selEAB2 = 2'b10;
        end
      end
      S_JMP: begin
        bus.SR1     = bus.IR[8:6];
        bus.selEAB1 = 1'b1;
        bus.selPC   = 2'b01;
        bus.ldPC    = 1'b1;
        bus.retire  = 1'b1;
      end
      S_JSR: begin
        bus.enaPC  = 1'b1;
        bus.DR     = 3'd7;
        bus.regWE  = 1'b1;
        bus.ldPC   = 1'b1;
        bus.selPC  = 2'b01;
        bus.retire = 1'b1;
        if (bus.IR[11]) begin
          bus.selEAB2 = 2'b11;
        end else begin
          bus.selEAB1 = 1'b1;
          bus.SR1     = bus.IR[8:6];
        end
      end
      S_LEA: begin
        bus.enaMARM = 1'b1;
        bus.selEAB2 = 2'b10;
        bus.DR      = bus.IR[11:9];
        bus.regWE   = 1'b1;
        bus.retire  = 1'b1;
      end
      S_AD: begin
        bus.enaMARM = 1'b1;
        bus.ldMAR   = 1'b1;
        if (opcode == OP_LDR || opcode == OP_STR) begin
          bus.selEAB1 = 1'b1;
          bus.SR1     = bus.IR[8:6];
          bus.selEAB2 = 2'b01;
        end else begin
          bus.selEAB2 = 2'b10;
        end
      end
`ifdef LC3_INDIRECT_EN
      S_IND: begin
        bus.enaMDR = 1'b1;
        bus.ldMAR  = 1'b1;
      end
`endif
      S_LDW: begin
        bus.enaMDR = 1'b1;
        bus.DR     = bus.IR[11:9];
        bus.regWE  = 1'b1;
        bus.flagWE = 1'b1;
        bus.retire = 1'b1;
      end
      S_STD: begin
        bus.SR1    = bus.IR[11:9];
        bus.enaALU = 1'b1;
        bus.ldMDR  = 1'b1;
      end
      S_WR: begin
        bus.memEN  = 1'b1;
        bus.memWE  = 1'b1;
        bus.retire = bus.mem_ready;
      end
      S_TR0: begin
        bus.enaPC = 1'b1;
        bus.DR    = 3'd7;
        bus.regWE = 1'b1;
      end
      S_TR1: begin
        bus.enaMARM = 1'b1;
        bus.selMAR  = 1'b1;
        bus.ldMAR   = 1'b1;
      end
      S_TR3: begin
        bus.enaMDR = 1'b1;
        bus.selPC  = 2'b10;
        bus.ldPC   = 1'b1;
        bus.retire = 1'b1;
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for lc3_control: fetch, ALU, branch, JSR, load with wait states,
// trap, store interrupted by reset, LDI (either build) and halt opcodes.
module tb_lc3_control;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  lc3_control_if u_if ();
  lc3_control dut (.clk(clk), .rst(rst), .bus(u_if.master));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // All outputs packed, MSB aluControl ... LSB retire (halted is bit 1).
  function automatic logic [31:0] outs();
    return {u_if.aluControl, u_if.SR1, u_if.SR2, u_if.DR, u_if.selPC, u_if.selEAB1,
            u_if.selEAB2, u_if.selMAR, u_if.selMDR, u_if.enaALU, u_if.enaPC,
            u_if.enaMARM, u_if.enaMDR, u_if.ldPC, u_if.ldIR, u_if.ldMAR, u_if.ldMDR,
            u_if.regWE, u_if.flagWE, u_if.memEN, u_if.memWE, u_if.halted, u_if.retire};
  endfunction

  // Advance one clock, apply mem_ready just after the edge, sample on the falling edge.
  task automatic cycle(input logic mr);
    @(posedge clk);
    #1 u_if.mem_ready = mr;
    @(negedge clk);
  endtask

  // Runs F0..DEC with memory always ready; returns while the DUT is in DEC.
  task automatic fetch(input logic [15:0] instr, input string nm);
    u_if.IR = instr;
    cycle(1'b1);
    check({nm, " F0"}, {u_if.enaPC, u_if.ldPC, u_if.ldMAR, u_if.memEN, u_if.selPC}, 6'b111000);
    cycle(1'b1);
    check({nm, " F1"}, {u_if.memEN, u_if.selMDR, u_if.ldMDR, u_if.ldIR}, 4'b1110);
    cycle(1'b1);
    check({nm, " F2"}, {u_if.enaMDR, u_if.ldIR, u_if.memEN}, 3'b110);
    cycle(1'b1);
    check({nm, " DEC"}, outs(), 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    u_if.IR = 16'h0;
    u_if.N = 1'b0;
    u_if.Z = 1'b0;
    u_if.P = 1'b0;
    u_if.mem_ready = 1'b0;
    cycle(1'b0);
    cycle(1'b1);
    check("reset outs", outs(), 32'h0);
    rst = 1'b1;

    // ADD R1,R2,#-3
    fetch(16'h12BD, "add");
    cycle(1'b1);
    check("add sr1", u_if.SR1, 3'd2);
    check("add sr2", u_if.SR2, 3'd5);
    check("add dr", u_if.DR, 3'd1);
    check("add alu", u_if.aluControl, 2'b01);
    check("add strobes", {u_if.enaALU, u_if.regWE, u_if.flagWE, u_if.retire, u_if.memEN}, 5'b11110);

    // BRz taken and not taken
    u_if.Z = 1'b1;
    fetch(16'h0405, "brz_t");
    cycle(1'b1);
    check("brz_t ld/ret", {u_if.ldPC, u_if.retire}, 2'b11);
    check("brz_t sel", {u_if.selPC, u_if.selEAB1, u_if.selEAB2}, 5'b01010);
    u_if.Z = 1'b0;
    u_if.P = 1'b1;
    fetch(16'h0405, "brz_n");
    cycle(1'b1);
    check("brz_n ld/ret", {u_if.ldPC, u_if.retire}, 2'b01);

    // JSR with PC-relative offset
    fetch(16'h4802, "jsr");
    cycle(1'b1);
    check("jsr strobes", {u_if.enaPC, u_if.regWE, u_if.ldPC, u_if.retire}, 4'b1111);
    check("jsr dr", u_if.DR, 3'd7);
    check("jsr sel", {u_if.selPC, u_if.selEAB1, u_if.selEAB2}, 5'b01011);

    // LD R1 with three wait cycles in RD
    fetch(16'h2202, "ld");
    cycle(1'b0);
    check("ld ad", {u_if.enaMARM, u_if.ldMAR, u_if.selMAR, u_if.selEAB1, u_if.selEAB2}, 6'b110010);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      check("ld rd wait", {u_if.memEN, u_if.selMDR, u_if.ldMDR, u_if.retire}, 4'b1100);
    end
    cycle(1'b1);
    check("ld rd done", {u_if.memEN, u_if.ldMDR}, 2'b11);
    cycle(1'b0);
    check("ld ldw", {u_if.enaMDR, u_if.regWE, u_if.flagWE, u_if.retire, u_if.memEN}, 5'b11110);
    check("ld ldw dr", u_if.DR, 3'd1);

    // TRAP x25
    fetch(16'hF025, "trap");
    cycle(1'b0);
    check("tr0", {u_if.enaPC, u_if.regWE, u_if.DR}, 5'b11111);
    cycle(1'b0);
    check("tr1", {u_if.enaMARM, u_if.selMAR, u_if.ldMAR, u_if.memEN}, 4'b1110);
    cycle(1'b1);
    check("tr2", {u_if.memEN, u_if.ldMDR}, 2'b11);
    cycle(1'b0);
    check("tr3", {u_if.enaMDR, u_if.ldPC, u_if.retire, u_if.selPC}, 5'b11110);

    // ST R3, reset while the write is waiting
    fetch(16'h3602, "st");
    cycle(1'b0);
    check("st ad", {u_if.ldMAR, u_if.selEAB2}, 3'b110);
    cycle(1'b0);
    check("st std", {u_if.SR1, u_if.enaALU, u_if.ldMDR, u_if.selMDR, u_if.aluControl}, 8'b01111000);
    cycle(1'b0);
    check("st wr", {u_if.memEN, u_if.memWE, u_if.retire}, 3'b110);
    cycle(1'b0);
    check("st wr hold", {u_if.memEN, u_if.memWE, u_if.retire}, 3'b110);
    rst = 1'b0;
    cycle(1'b1);
    check("st rst mem", {u_if.memEN, u_if.memWE, u_if.ldPC}, 3'b000);
    check("st rst outs", outs(), 32'h0);
    rst = 1'b1;

    // LDI R0
    fetch(16'hA002, "ldi");
`ifdef LC3_INDIRECT_EN
    cycle(1'b1);
    check("ldi ad", {u_if.enaMARM, u_if.ldMAR}, 2'b11);
    cycle(1'b1);
    check("ldi rd1", {u_if.memEN, u_if.ldMDR}, 2'b11);
    cycle(1'b1);
    check("ldi ind", {u_if.enaMDR, u_if.ldMAR, u_if.memEN}, 3'b110);
    cycle(1'b1);
    check("ldi rd2", {u_if.memEN, u_if.ldMDR}, 2'b11);
    cycle(1'b1);
    check("ldi ldw", {u_if.enaMDR, u_if.regWE, u_if.retire, u_if.DR}, 6'b111000);
`else
    cycle(1'b1);
    check("ldi halt", outs(), 32'h2);
    cycle(1'b1);
    check("ldi halt hold", outs(), 32'h2);
`endif

    // Opcode 1101 halts until reset; mem_ready is ignored there
    rst = 1'b0;
    cycle(1'b0);
    rst = 1'b1;
    fetch(16'hD000, "op1101");
    cycle(1'b1);
    check("op1101 halt", outs(), 32'h2);
    cycle(1'b0);
    check("op1101 hold", outs(), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
